// File: rtl/vm_pkg.sv
// Shared definitions for the N-product vending controller.
//   state_t   : top-level controller states
//   HALF_UNIT : value of a 0.5 TL coin in credit units
//   ONE_UNIT  : value of a 1 TL coin in credit units
package vm_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    VEND    = 2'd1,
    CHANGE  = 2'd2
  } state_t;

  localparam int unsigned HALF_UNIT = 1;
  localparam int unsigned ONE_UNIT  = 2;

endpackage

// File: rtl/vm_change_payout.sv
// Serial change payout: holds the amount still owed and returns it one coin
// per cycle, largest coin first.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : take load_val as the amount owed (may coincide with step)
//   load_val   : amount owed, 0.5 TL units
//   step       : emit one coin on this edge
//   change1    : registered pulse, one 1 TL coin
//   change05   : registered pulse, one 0.5 TL coin
//   done       : the coin currently being output is the last one
//   remain     : amount still owed after the coin currently being output
module vm_change_payout
  import vm_pkg::*;
#(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          step,
  output logic          change1,
  output logic          change05,
  output logic          done,
  output logic [CW-1:0] remain
);

  logic [CW-1:0] src;

  // A load and a step on the same edge pay the first coin straight from the
  // loaded value, so a refund starts paying without an idle cycle.
  assign src  = load ? load_val : remain;
  assign done = (change1 || change05) && (remain == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain   <= '0;
      change1  <= 1'b0;
      change05 <= 1'b0;
    end else if (step && (src >= CW'(ONE_UNIT))) begin
      remain   <= src - CW'(ONE_UNIT);
      change1  <= 1'b1;
      change05 <= 1'b0;
    end else if (step && (src != '0)) begin
      remain   <= src - CW'(HALF_UNIT);
      change1  <= 1'b0;
      change05 <= 1'b1;
    end else begin
      remain   <= src;
      change1  <= 1'b0;
      change05 <= 1'b0;
    end
  end

endmodule

// File: rtl/vending_machine_np.sv
// N-product coin vending controller: collects 0.5/1 TL coins up to a credit
// ceiling, vends the selected product, pays change serially, supports refund
// and restock.
//   Clk        : clock, rising edge
//   Req_n      : asynchronous active-low reset
//   OneTL      : 1 TL coin pulse
//   HalfTL     : 0.5 TL coin pulse
//   Sel        : product select, lowest asserted index wins
//   Cancel     : refund request
//   Restock    : reload all stock counters
//   Dispense   : one-hot vend pulse
//   Change1    : return one 1 TL coin
//   Change05   : return one 0.5 TL coin
//   CoinReject : coin(s) of the previous cycle bounced
//   Credit     : current credit, 0.5 TL units
//   SoldOut    : bit i set when product i stock is empty
//   Busy       : vending or paying change
module vending_machine_np
  import vm_pkg::*;
#(
  parameter int unsigned          N_PROD     = 2,
  parameter int unsigned          CW         = 4,
  parameter logic [N_PROD*CW-1:0] PRICES     = {4'd5, 4'd3},
  parameter int unsigned          MAX_CREDIT = 6,
  parameter int unsigned          STOCK_W    = 4,
  parameter int unsigned          STOCK_INIT = 15
) (
  input  logic              Clk,
  input  logic              Req_n,
  input  logic              OneTL,
  input  logic              HalfTL,
  input  logic [N_PROD-1:0] Sel,
  input  logic              Cancel,
  input  logic              Restock,
  output logic [N_PROD-1:0] Dispense,
  output logic              Change1,
  output logic              Change05,
  output logic              CoinReject,
  output logic [CW-1:0]     Credit,
  output logic [N_PROD-1:0] SoldOut,
  output logic              Busy
);

  state_t            state, state_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic [N_PROD-1:0] sel_first, can_buy, sold_out, dispense_d;
  logic [CW-1:0]     price_masked [N_PROD];
  logic [CW-1:0]     price_sel;
  logic [CW:0]       coin_add, credit_sum;
  logic              coin_any, valid_sel, take, restock_en, reject_d;
  logic              pay_load, pay_step, pay_done;
  logic [CW-1:0]     pay_val, remain;

  // Isolate the lowest asserted select bit.
  assign sel_first  = Sel & (~Sel + N_PROD'(1));
  assign coin_any   = OneTL || HalfTL;
  assign coin_add   = (OneTL  ? (CW+1)'(ONE_UNIT)  : '0)
                    + (HalfTL ? (CW+1)'(HALF_UNIT) : '0);
  // One extra bit so the ceiling check cannot wrap.
  assign credit_sum = {1'b0, credit_q} + coin_add;
  assign valid_sel  = |can_buy;

  for (genvar i = 0; i < N_PROD; i++) begin : g_prod
    logic [STOCK_W-1:0] stock;
    logic [CW-1:0]      price;

    assign price           = PRICES[CW*i +: CW];
    assign can_buy[i]      = sel_first[i] && (stock != '0) && (credit_q >= price);
    assign price_masked[i] = sel_first[i] ? price : '0;
    assign sold_out[i]     = (stock == '0);

    always_ff @(posedge Clk or negedge Req_n) begin
      if (!Req_n) begin
        stock <= STOCK_W'(STOCK_INIT);
      end else if (restock_en) begin
        stock <= STOCK_W'(STOCK_INIT);
      end else if (take && sel_first[i] && (stock != '0)) begin
        stock <= stock - STOCK_W'(1);
      end
    end
  end

  always_comb begin
    price_sel = '0;
    for (int unsigned i = 0; i < N_PROD; i++) begin
      price_sel = price_sel | price_masked[i];
    end
  end

  always_comb begin
    state_d    = state;
    credit_d   = credit_q;
    dispense_d = '0;
    reject_d   = 1'b0;
    take       = 1'b0;
    restock_en = 1'b0;
    pay_load   = 1'b0;
    pay_val    = '0;
    pay_step   = 1'b0;
    unique case (state)
      COLLECT: begin
        if (valid_sel) begin
          state_d    = VEND;
          take       = 1'b1;
          dispense_d = sel_first;
          pay_load   = 1'b1;
          pay_val    = credit_q - price_sel;
          credit_d   = '0;
          reject_d   = coin_any;
        end else if (Cancel && (credit_q != '0)) begin
          state_d  = CHANGE;
          pay_load = 1'b1;
          pay_val  = credit_q;
          pay_step = 1'b1;
          credit_d = '0;
          reject_d = coin_any;
        end else if (coin_any) begin
          if (credit_sum <= (CW+1)'(MAX_CREDIT)) begin
            credit_d = credit_sum[CW-1:0];
          end else begin
            reject_d = 1'b1;
          end
        end else if (Restock) begin
          restock_en = 1'b1;
        end
      end
      VEND: begin
        reject_d = coin_any;
        if (remain != '0) begin
          state_d  = CHANGE;
          pay_step = 1'b1;
        end else begin
          state_d = COLLECT;
        end
      end
      CHANGE: begin
        reject_d = coin_any;
        if (pay_done) begin
          state_d = COLLECT;
        end else begin
          pay_step = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge Clk or negedge Req_n) begin
    if (!Req_n) begin
      state      <= COLLECT;
      credit_q   <= '0;
      Dispense   <= '0;
      CoinReject <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      state      <= state_d;
      credit_q   <= credit_d;
      Dispense   <= dispense_d;
      CoinReject <= reject_d;
      Busy       <= (state_d != COLLECT);
    end
  end

  vm_change_payout #(
    .CW(CW)
  ) u_payout (
    .clk      (Clk),
    .rst_n    (Req_n),
    .load     (pay_load),
    .load_val (pay_val),
    .step     (pay_step),
    .change1  (Change1),
    .change05 (Change05),
    .done     (pay_done),
    .remain   (remain)
  );

  assign Credit  = credit_q;
  assign SoldOut = sold_out;

endmodule

// File: tb/tb_vending_machine_np.sv
// Self-checking bench for vending_machine_np: directed scenarios followed by
// random coin/select/cancel/restock traffic, checked every cycle against a
// transaction-level model (credit, stock table, queue of scheduled outputs).
module tb_vending_machine_np;

  logic       Clk = 1'b0;
  logic       Req_n, OneTL, HalfTL, Cancel, Restock;
  logic [1:0] Sel, Dispense, SoldOut;
  logic       Change1, Change05, CoinReject, Busy;
  logic [3:0] Credit;

  int total = 0;
  int bad   = 0;

  localparam int STOCK0 = 3;

  vending_machine_np #(
    .N_PROD     (2),
    .CW         (4),
    .PRICES     ({4'd5, 4'd3}),
    .MAX_CREDIT (6),
    .STOCK_W    (4),
    .STOCK_INIT (STOCK0)
  ) dut (
    .Clk        (Clk),
    .Req_n      (Req_n),
    .OneTL      (OneTL),
    .HalfTL     (HalfTL),
    .Sel        (Sel),
    .Cancel     (Cancel),
    .Restock    (Restock),
    .Dispense   (Dispense),
    .Change1    (Change1),
    .Change05   (Change05),
    .CoinReject (CoinReject),
    .Credit     (Credit),
    .SoldOut    (SoldOut),
    .Busy       (Busy)
  );

  always #5 Clk = ~Clk;

  // Reference model: one queue entry per busy cycle (vend pulse or coin).
  typedef struct packed {
    logic [1:0] disp;
    logic       c1;
    logic       c05;
  } ent_t;

  ent_t sched[$];
  int   m_credit;
  int   m_stock[2];
  int   price[2] = '{3, 5};
  bit   m_busy;
  logic [1:0] e_disp, e_sold;
  logic       e_c1, e_c05, e_rej, e_busy;
  logic [3:0] e_credit;

  task automatic model_reset();
    sched.delete();
    m_credit = 0;
    m_stock[0] = STOCK0;
    m_stock[1] = STOCK0;
    m_busy = 1'b0;
    e_disp = '0; e_c1 = 1'b0; e_c05 = 1'b0; e_rej = 1'b0; e_busy = 1'b0;
    e_credit = '0;
    e_sold = '0;
  endtask

  task automatic push_coins(input int r);
    int v = r;
    while (v >= 2) begin
      sched.push_back(ent_t'{disp: 2'b00, c1: 1'b1, c05: 1'b0});
      v -= 2;
    end
    if (v == 1) sched.push_back(ent_t'{disp: 2'b00, c1: 1'b0, c05: 1'b1});
  endtask

  task automatic pop_entry();
    ent_t e = sched.pop_front();
    e_disp = e.disp;
    e_c1   = e.c1;
    e_c05  = e.c05;
    m_busy = 1'b1;
  endtask

  task automatic model_edge(input logic one, input logic half, input logic [1:0] sel,
                            input logic can, input logic rst_k);
    int  add  = (one ? 2 : 0) + (half ? 1 : 0);
    bit  coin = one || half;
    int  idx  = -1;
    e_disp = '0; e_c1 = 1'b0; e_c05 = 1'b0; e_rej = 1'b0;
    if (m_busy) begin
      e_rej = coin;
      if (sched.size() > 0) pop_entry();
      else m_busy = 1'b0;
    end else begin
      if (sel[0]) idx = 0;
      else if (sel[1]) idx = 1;
      if (idx >= 0 && m_stock[idx] > 0 && m_credit >= price[idx]) begin
        sched.push_back(ent_t'{disp: 2'(1 << idx), c1: 1'b0, c05: 1'b0});
        push_coins(m_credit - price[idx]);
        m_stock[idx]--;
        m_credit = 0;
        e_rej = coin;
        pop_entry();
      end else if (can && m_credit > 0) begin
        push_coins(m_credit);
        m_credit = 0;
        e_rej = coin;
        pop_entry();
      end else if (coin) begin
        if (m_credit + add <= 6) m_credit += add;
        else e_rej = 1'b1;
      end else if (rst_k) begin
        m_stock[0] = STOCK0;
        m_stock[1] = STOCK0;
      end
    end
    e_busy   = m_busy;
    e_credit = 4'(m_credit);
    e_sold   = {m_stock[1] == 0, m_stock[0] == 0};
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dispense"}, 8'(Dispense),   8'(e_disp));
    chk({tag, ".change1"},  8'(Change1),    8'(e_c1));
    chk({tag, ".change05"}, 8'(Change05),   8'(e_c05));
    chk({tag, ".reject"},   8'(CoinReject), 8'(e_rej));
    chk({tag, ".credit"},   8'(Credit),     8'(e_credit));
    chk({tag, ".soldout"},  8'(SoldOut),    8'(e_sold));
    chk({tag, ".busy"},     8'(Busy),       8'(e_busy));
  endtask

  task automatic cyc(input string tag, input logic one, input logic half,
                     input logic [1:0] sel, input logic can, input logic rst_k);
    @(negedge Clk);
    OneTL = one; HalfTL = half; Sel = sel; Cancel = can; Restock = rst_k;
    @(posedge Clk);
    #1;
    model_edge(one, half, sel, can, rst_k);
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    Req_n = 1'b1; OneTL = 1'b0; HalfTL = 1'b0; Sel = '0; Cancel = 1'b0; Restock = 1'b0;
    #2 Req_n = 1'b0;
    #10;
    model_reset();
    check_all("reset");
    @(negedge Clk);
    Req_n = 1'b1;

    // Exact payment for product 0: no change.
    cyc("coin1", 1, 0, 2'b00, 0, 0);
    cyc("coin05", 0, 1, 2'b00, 0, 0);
    cyc("buy0", 0, 0, 2'b01, 0, 0);
    idle("after_buy0", 2);

    // Credit 6, product 1 (price 5): one 0.5 TL coin back.
    for (int i = 0; i < 3; i++) cyc("fill6a", 1, 0, 2'b00, 0, 0);
    cyc("buy1", 0, 0, 2'b10, 0, 0);
    idle("chg_buy1", 3);

    // Credit 6, product 0 (price 3): 1 TL then 0.5 TL back.
    for (int i = 0; i < 3; i++) cyc("fill6b", 1, 0, 2'b00, 0, 0);
    cyc("buy0b", 0, 0, 2'b01, 0, 0);
    idle("chg_buy0b", 3);

    // Overflow reject, then refund with a coin during payout.
    for (int i = 0; i < 3; i++) cyc("fill6c", 1, 0, 2'b00, 0, 0);
    cyc("overflow", 1, 0, 2'b00, 0, 0);
    cyc("overflow05", 0, 1, 2'b00, 0, 0);
    cyc("cancel", 0, 0, 2'b00, 1, 0);
    cyc("coin_in_pay", 0, 1, 2'b00, 0, 0);
    idle("refund", 3);

    // Empty product 0 (one left), then a select it cannot serve, then restock.
    cyc("so_c1", 1, 0, 2'b00, 0, 0);
    cyc("so_c2", 0, 1, 2'b00, 0, 0);
    cyc("so_buy", 0, 0, 2'b01, 0, 0);
    idle("so_idle", 2);
    cyc("so_c3", 1, 0, 2'b00, 0, 0);
    cyc("so_c4", 0, 1, 2'b00, 0, 0);
    cyc("so_sel_ignored", 0, 0, 2'b01, 0, 0);
    cyc("so_both_sel", 0, 0, 2'b11, 0, 0);
    cyc("restock", 0, 0, 2'b00, 0, 1);
    cyc("cancel_small", 0, 0, 2'b00, 1, 0);
    idle("so_refund", 3);

    // Cancel with zero credit is ignored.
    cyc("cancel_zero", 0, 0, 2'b00, 1, 0);

    // Asynchronous reset in the middle of a refund payout.
    for (int i = 0; i < 3; i++) cyc("fill6d", 1, 0, 2'b00, 0, 0);
    cyc("cancel2", 0, 0, 2'b00, 1, 0);
    idle("second_c1", 1);
    #2 Req_n = 1'b0;
    #1;
    model_reset();
    check_all("midrst");
    @(negedge Clk);
    Req_n = 1'b1;
    idle("post_rst", 4);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      logic one, half, can, rk;
      logic [1:0] sel;
      one  = ($urandom_range(0, 99) < 25);
      half = ($urandom_range(0, 99) < 25);
      sel  = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00;
      can  = ($urandom_range(0, 99) < 6);
      rk   = ($urandom_range(0, 99) < 3);
      cyc("rand", one, half, sel, can, rk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
